// File: rtl/mipi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_rx_pkg
//  Description : Shared types and constants for the MIPI CSI-2 receive bridge
//                (lane-aligner state encoding, sync byte, lane limit).
//  Revision    : 1.0  initial release
// ============================================================================
package mipi_rx_pkg;

   // Byte the per-lane byte aligners search for before asserting valid
   localparam logic [7:0] MIPI_SYNC_BYTE = 8'hB8;

   // Widest lane configuration the bridge supports
   localparam int MIPI_MAX_LANES = 4;

   // Lane-aligner control states
   typedef enum logic [1:0] {
      LA_IDLE   = 2'd0,
      LA_WAIT   = 2'd1,
      LA_LOCKED = 2'd2,
      LA_ERROR  = 2'd3
   } la_state_t;

endpackage : mipi_rx_pkg
`default_nettype wire

// File: rtl/mipi_rx_lane_delay.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_rx_lane_delay
//  Description : One lane's {valid, byte} delay line with a tap-select mux.
//                Tap 0 is the live input; tap t is the input t cycles ago.
//  Revision    : 1.0  initial release
// ============================================================================
module mipi_rx_lane_delay
   import mipi_rx_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAP_W = 2
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic [7:0]       byte_i,
   input  logic             valid_i,
   input  logic [TAP_W-1:0] tap_i,
   output logic [7:0]       byte_o,
   output logic             valid_o
);

   // stage[i] holds {valid, byte} as seen on the input i cycles ago
   logic [8:0] stage [1:DEPTH-1];
   logic [8:0] sel;

   // Shift the lane history by one byte clock
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 1; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[1] <= {valid_i, byte_i};
         for (int i = 2; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   // Pick the history entry addressed by the tap; unused tap codes read as tap 0
   always_comb begin
      sel = {valid_i, byte_i};
      for (int i = 1; i < DEPTH; i++) begin
         if (tap_i == TAP_W'(i)) sel = stage[i];
      end
   end

   assign valid_o = sel[8];
   assign byte_o  = sel[7:0];

endmodule : mipi_rx_lane_delay
`default_nettype wire

// File: rtl/mipi_rx_lane_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_rx_lane_aligner
//  Description : Multi-lane deskew. Delays early lanes so the first post-sync
//                byte of every lane lands in the same output beat; pulses
//                error_o when inter-lane skew exceeds MAX_SKEW byte clocks.
//                Optional feature macro MIPI_RX_LANE_ERR_CNT_EN adds an 8-bit
//                saturating error counter output err_count_o.
//  Revision    : 1.0  initial release
// ============================================================================
module mipi_rx_lane_aligner
   import mipi_rx_pkg::*;
#(
   parameter int LANES    = 2,
   parameter int MAX_SKEW = 3
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [8*LANES-1:0] bytes_i,
   input  logic [LANES-1:0]   valid_i,
   output logic [8*LANES-1:0] bytes_o,
   output logic               valid_o,
   output logic               error_o
`ifdef MIPI_RX_LANE_ERR_CNT_EN
   ,
   output logic [7:0]         err_count_o
`endif
);

   localparam int               TAP_W      = $clog2(MAX_SKEW + 1);
   localparam logic [TAP_W-1:0] SKEW_LIMIT = TAP_W'(MAX_SKEW);
   localparam logic [TAP_W-1:0] TAP_ONE    = TAP_W'(1);

   la_state_t          state;
   logic [TAP_W-1:0]   tap [LANES];
   logic [TAP_W-1:0]   skew_cnt;
   logic [TAP_W-1:0]   skew_nxt;
   logic [8*LANES-1:0] dly_bytes;
   logic [LANES-1:0]   dly_valid;
   logic               all_valid;
   logic               any_valid;
   logic               lock_now;
   logic               capture;

   assign all_valid = &valid_i;
   assign any_valid = |valid_i;
   assign skew_nxt  = skew_cnt + TAP_ONE;
   // The cycle the last lane arrives already drives the output from final taps
   assign lock_now  = ((state == LA_IDLE) || (state == LA_WAIT)) && all_valid;
   assign capture   = lock_now || (state == LA_LOCKED);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      mipi_rx_lane_delay #(
         .DEPTH (MAX_SKEW + 1),
         .TAP_W (TAP_W)
      ) u_delay (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .byte_i    (bytes_i[8*k +: 8]),
         .valid_i   (valid_i[k]),
         .tap_i     (tap[k]),
         .byte_o    (dly_bytes[8*k +: 8]),
         .valid_o   (dly_valid[k])
      );
   end

   // Control FSM, tap capture and registered outputs
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state    <= LA_IDLE;
         skew_cnt <= '0;
         for (int k = 0; k < LANES; k++) tap[k] <= '0;
         bytes_o  <= '0;
         valid_o  <= 1'b0;
         error_o  <= 1'b0;
      end else begin
         error_o <= 1'b0;
         case (state)
            LA_IDLE: begin
               if (all_valid) begin
                  state <= LA_LOCKED;
               end else if (any_valid) begin
                  state    <= LA_WAIT;
                  skew_cnt <= '0;
                  // Lanes already valid have one cycle of history by next cycle
                  for (int k = 0; k < LANES; k++) tap[k] <= valid_i[k] ? TAP_ONE : '0;
               end
            end
            LA_WAIT: begin
               if (all_valid) begin
                  state <= LA_LOCKED;
               end else begin
                  skew_cnt <= skew_nxt;
                  if (skew_nxt == SKEW_LIMIT) begin
                     state   <= LA_ERROR;
                     error_o <= 1'b1;
                     for (int k = 0; k < LANES; k++) tap[k] <= '0;
                  end else begin
                     for (int k = 0; k < LANES; k++) begin
                        if (valid_i[k]) tap[k] <= tap[k] + TAP_ONE;
                     end
                  end
               end
            end
            LA_LOCKED: begin
               if (!any_valid && !valid_o) begin
                  state <= LA_IDLE;
                  for (int k = 0; k < LANES; k++) tap[k] <= '0;
               end
            end
            LA_ERROR: begin
               if (!any_valid) state <= LA_IDLE;
            end
            default: state <= LA_IDLE;
         endcase

         // Once valid_o drops inside a packet it stays low until the next lock
         if (lock_now) begin
            valid_o <= &dly_valid;
         end else if (state == LA_LOCKED) begin
            valid_o <= valid_o & (&dly_valid);
         end else begin
            valid_o <= 1'b0;
         end
         bytes_o <= capture ? dly_bytes : '0;
      end
   end

`ifdef MIPI_RX_LANE_ERR_CNT_EN
   // Saturating count of skew errors since reset
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_count_o <= '0;
      end else if (error_o && (err_count_o != 8'hFF)) begin
         err_count_o <= err_count_o + 8'd1;
      end
   end
`endif

endmodule : mipi_rx_lane_aligner
`default_nettype wire

// File: tb/tb_mipi_rx_lane_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mipi_rx_lane_aligner
//  Description : Directed self-checking bench for mipi_rx_lane_aligner with a
//                2-lane and a 4-lane instance (MAX_SKEW=3 for both).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mipi_rx_lane_aligner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] bytes2;
   logic [1:0]  valid2;
   logic [15:0] out2;
   logic        vo2;
   logic        err2;
   logic [31:0] bytes4;
   logic [3:0]  valid4;
   logic [31:0] out4;
   logic        vo4;
   logic        err4;
`ifdef MIPI_RX_LANE_ERR_CNT_EN
   logic [7:0]  cnt2;
   logic [7:0]  cnt4;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mipi_rx_lane_aligner #(.LANES(2), .MAX_SKEW(3)) dut2 (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bytes_i   (bytes2),
      .valid_i   (valid2),
      .bytes_o   (out2),
      .valid_o   (vo2),
      .error_o   (err2)
`ifdef MIPI_RX_LANE_ERR_CNT_EN
      ,
      .err_count_o (cnt2)
`endif
   );

   mipi_rx_lane_aligner #(.LANES(4), .MAX_SKEW(3)) dut4 (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bytes_i   (bytes4),
      .valid_i   (valid4),
      .bytes_o   (out4),
      .valid_o   (vo4),
      .error_o   (err4)
`ifdef MIPI_RX_LANE_ERR_CNT_EN
      ,
      .err_count_o (cnt4)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step2(input logic [15:0] b, input logic [1:0] v);
      bytes2 = b;
      valid2 = v;
      tick();
   endtask

   task automatic step4(input logic [31:0] b, input logic [3:0] v);
      bytes4 = b;
      valid4 = v;
      tick();
   endtask

   // Lane 1 never arrives: skew counter hits MAX_SKEW on the 4th cycle
   task automatic err_burst2();
      for (int i = 0; i < 4; i++) step2(16'h00E0, 2'b01);
      chk("err_pulse2", err2, 1);
      chk("err_vo2", vo2, 0);
      step2(16'h0000, 2'b00);
      chk("err_clear2", err2, 0);
      step2(16'h0000, 2'b00);
   endtask

   initial begin
      rst_n  = 1'b0;
      bytes2 = '0;
      valid2 = '0;
      bytes4 = '0;
      valid4 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vo2", vo2, 0);
      chk("rst_out2", out2, 0);
      chk("rst_err2", err2, 0);
      chk("rst_vo4", vo4, 0);
      chk("rst_out4", out4, 0);
      rst_n = 1'b1;
      tick();

      // Both lanes valid together
      step2(16'h2211, 2'b11);
      chk("t1_vo_a", vo2, 1);
      chk("t1_out_a", out2, 16'h2211);
      chk("t1_err_a", err2, 0);
      step2(16'h4433, 2'b11);
      chk("t1_vo_b", vo2, 1);
      chk("t1_out_b", out2, 16'h4433);
      step2(16'h0000, 2'b00);
      chk("t1_vo_end", vo2, 0);
      chk("t1_err_end", err2, 0);
      step2(16'h0000, 2'b00);
      step2(16'h0000, 2'b00);

      // Lane 0 leads lane 1 by two cycles
      step2(16'h00A0, 2'b01);
      chk("t2_vo_w0", vo2, 0);
      step2(16'h00A1, 2'b01);
      chk("t2_vo_w1", vo2, 0);
      step2(16'hB0A2, 2'b11);
      chk("t2_vo_a", vo2, 1);
      chk("t2_out_a", out2, 16'hB0A0);
      chk("t2_tap0", 32'(dut2.tap[0]), 2);
      chk("t2_tap1", 32'(dut2.tap[1]), 0);
      step2(16'hB100, 2'b10);
      chk("t2_vo_b", vo2, 1);
      chk("t2_out_b", out2, 16'hB1A1);
      step2(16'h0000, 2'b00);
      chk("t2_vo_end", vo2, 0);
      chk("t2_err", err2, 0);
      step2(16'h0000, 2'b00);
      step2(16'h0000, 2'b00);

      // Skew of exactly MAX_SKEW locks
      step2(16'h00C0, 2'b01);
      step2(16'h00C1, 2'b01);
      step2(16'h00C2, 2'b01);
      chk("t4_vo_w", vo2, 0);
      chk("t4_err_w", err2, 0);
      step2(16'hD0C3, 2'b11);
      chk("t4_vo_a", vo2, 1);
      chk("t4_out_a", out2, 16'hD0C0);
      chk("t4_err_a", err2, 0);
      step2(16'hD100, 2'b10);
      chk("t4_vo_b", vo2, 1);
      chk("t4_out_b", out2, 16'hD1C1);
      chk("t4_err_b", err2, 0);
      step2(16'h0000, 2'b00);
      chk("t4_vo_end", vo2, 0);
      step2(16'h0000, 2'b00);
      step2(16'h0000, 2'b00);

      // Skew of MAX_SKEW+1 on the 2-lane instance
      err_burst2();

      // 4 lanes, lane 3 arrives 4 cycles after the others
      for (int i = 0; i < 3; i++) begin
         step4(32'h00332211, 4'b0111);
         chk("t3_err_w", err4, 0);
      end
      step4(32'h00332211, 4'b0111);
      chk("t3_err_pulse", err4, 1);
      chk("t3_vo_pulse", vo4, 0);
      step4(32'h44332211, 4'b1111);
      chk("t3_err_once", err4, 0);
      chk("t3_vo_late", vo4, 0);
      step4(32'h44332211, 4'b1111);
      chk("t3_vo_late2", vo4, 0);
      step4(32'h00000000, 4'b0000);
      step4(32'h00000000, 4'b0000);
      step4(32'h44332211, 4'b1111);
      chk("t3_relock_vo", vo4, 1);
      chk("t3_relock_out", out4, 32'h44332211);
      chk("t3_relock_err", err4, 0);
      step4(32'h00000000, 4'b0000);
      chk("t3_relock_end", vo4, 0);
      step4(32'h00000000, 4'b0000);

      // Asynchronous reset in the middle of a locked packet
      step2(16'h5566, 2'b11);
      chk("t5_vo_a", vo2, 1);
      step2(16'h7788, 2'b11);
      chk("t5_out_b", out2, 16'h7788);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_vo", vo2, 0);
      chk("t5_async_out", out2, 0);
      bytes2 = '0;
      valid2 = '0;
      #3;
      rst_n = 1'b1;
      tick();
      step2(16'h9988, 2'b11);
      chk("t5_fresh_vo", vo2, 1);
      chk("t5_fresh_out", out2, 16'h9988);
      chk("t5_fresh_err", err2, 0);
      step2(16'h0000, 2'b00);
      step2(16'h0000, 2'b00);

`ifdef MIPI_RX_LANE_ERR_CNT_EN
      chk("cnt_after_rst", 32'(cnt2), 0);
      chk("cnt4_after_rst", 32'(cnt4), 0);
      for (int i = 0; i < 3; i++) err_burst2();
      chk("cnt_3", 32'(cnt2), 3);
      for (int i = 0; i < 297; i++) err_burst2();
      chk("cnt_sat", 32'(cnt2), 32'hFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mipi_rx_lane_aligner
`default_nettype wire

// File: doc/mipi_rx_lane_aligner.md
# mipi_rx_lane_aligner

Multi-lane deskew stage directly downstream of the per-lane `mipi_rx_byte_aligner` instances in the MIPI CSI-2 receive bridge. Each lane's byte aligner asserts its valid independently once it finds the 0xB8 sync byte, so lanes can start up to a few byte clocks apart. This block delays the early lanes so that the first post-sync byte of every lane appears in the same output beat. It flags an error when the inter-lane skew exceeds the configured window.

## Interface
- `LANES`, 2: number of data lanes, legal 1..4
- `MAX_SKEW`, 3: maximum tolerated lane-to-lane skew in byte clocks, legal 1..7
- `clk_i`  in  1  byte clock shared by all lanes
- `reset_n_i`  in  1  asynchronous, active-low reset
- `bytes_i`  in  8*LANES  aligned bytes from byte aligners, lane k at [8k+7:8k]
- `valid_i`  in  LANES  per-lane `byte_valid_o` from byte aligners
- `bytes_o`  out  8*LANES  deskewed bytes, same lane packing
- `valid_o`  out  1  all lanes of `bytes_o` valid
- `error_o`  out  1  one-cycle pulse, skew window exceeded

## Operation
- Per lane: delay line of depth MAX_SKEW+1 holding {valid, byte}; tap 0 = current input.
- Per lane tap register `tap_k`, width clog2(MAX_SKEW+1), and a skew counter `skew_cnt` of the same width.
- FSM states: IDLE, WAIT, LOCKED, ERROR.
- IDLE: all taps 0.
  - If every `valid_i` is high in the same cycle: go to LOCKED with all taps 0.
  - Else, if any `valid_i` is high: go to WAIT, `skew_cnt` = 0.
- WAIT: each cycle, `tap_k` increments for every lane whose valid is already high and whose tap was captured earlier. Lanes not yet valid hold 0.
  - All lanes valid: go to LOCKED and freeze the taps. The latest lane has tap 0.
  - `skew_cnt` reaches MAX_SKEW with any lane still invalid: go to ERROR and pulse `error_o`.
- LOCKED:
  - `bytes_o` lane k is registered from delay-line tap `tap_k`.
  - `valid_o` is registered as the AND of the delayed valids at each lane's tap.
  - Go to IDLE when all `valid_i` are low and the registered `valid_o` is low.
- ERROR: `valid_o` held 0. Go to IDLE once all `valid_i` are low.
- A lane dropping valid in LOCKED ends the packet for that lane. `valid_o` falls when the first delayed valid falls; no re-lock mid-packet.
- `LANES`=1: IDLE goes straight to LOCKED on valid. Pure one-cycle register, WAIT and ERROR unreachable.
- `reset_n_i` low at any time, including mid-packet: the asynchronous reset clears the FSM and all state.

## Timing
- Reset values: `bytes_o`=0, `valid_o`=0, `error_o`=0, FSM=IDLE, taps/counters/delay lines 0.
- Latency: the first `valid_o` beat occurs 1 cycle after the latest lane's first `valid_i`. It carries the first post-sync byte of every lane.
- Steady-state latency for lane k is `tap_k`+1 cycles. The output is continuous while all delayed valids are high.
- Skew of exactly MAX_SKEW cycles locks. Skew of MAX_SKEW+1 cycles errors.
- `error_o` is high for exactly one cycle: the WAIT→ERROR transition cycle +1, registered.
- Simultaneous events: the last lane arriving on the same cycle `skew_cnt` hits MAX_SKEW locks; locking has priority over error.

## Configuration
- `MIPI_RX_LANE_ERR_CNT_EN`: when defined, adds output `err_count_o` [7:0].
  - Increments on every `error_o` pulse and saturates at 0xFF.
  - Clears only on reset.
- When undefined, the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `mipi_rx_pkg`:
  - lane-aligner FSM state enum
  - `MIPI_SYNC_BYTE` = 8'hB8
  - max-lane constant (4)
- Sub-module `mipi_rx_lane_delay`: one lane's {valid, byte} delay line with a tap-select mux. Instantiated LANES times in a generate loop.
- The FSM and tap capture live in the top module.

## Test plan
- LANES=2, both lanes valid in the same cycle with bytes 0x11/0x22 then 0x33/0x44 → `valid_o` high next cycle, `bytes_o`=0x2211 then 0x4433, `error_o` never high.
- LANES=2, lane0 valid 2 cycles before lane1; lane0 sends 0xA0,0xA1,0xA2; lane1 sends 0xB0,0xB1 → first `valid_o` beat `bytes_o`=0xB0A0, then 0xB1A1; `tap_0`=2, `tap_1`=0.
- LANES=4, MAX_SKEW=3, lane3 arrives 4 cycles after lane0 → single `error_o` pulse, `valid_o` stays 0; after all valids low, the FSM returns to IDLE and the next clean burst locks.
- LANES=2, skew exactly 3 with MAX_SKEW=3 → locks, no error, first beat aligned.
- `reset_n_i` pulsed low mid-LOCKED → `valid_o`/`bytes_o` go to 0 immediately, without waiting for a clock edge; a fresh burst after release locks normally.
- With `MIPI_RX_LANE_ERR_CNT_EN` defined, 3 error bursts → `err_count_o`=3; 300 error bursts → `err_count_o`=0xFF.
